// File: rtl/sum_seq_pkg.sv
// Shared encodings and default widths for the sequential sum-of-first-N arbiter.
// Optional overflow flag is controlled by the SUM_OVF_EN macro in the users of this package.
package sum_seq_pkg;

  localparam int DEF_WN = 4;
  localparam int DEF_WS = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sum_seq_arbiter_if.sv
// Requester-side bundle of sum_seq_arbiter: two request/operand pairs and the shared result.
// SUM_OVF_EN adds the sticky overflow flag ovf.
interface sum_seq_arbiter_if
  import sum_seq_pkg::*;
#(
  parameter int WN = DEF_WN,
  parameter int WS = DEF_WS
);

  logic          req0;
  logic [WN-1:0] n0;
  logic          req1;
  logic [WN-1:0] n1;
  logic          gnt0;
  logic          gnt1;
  logic          busy;
  logic          owner;
  logic          done0;
  logic          done1;
  logic [WS-1:0] sum;
`ifdef SUM_OVF_EN
  logic          ovf;
`endif

  modport master (
    output req0, n0, req1, n1,
`ifdef SUM_OVF_EN
    input  ovf,
`endif
    input  gnt0, gnt1, busy, owner, done0, done1, sum
  );

  modport slave (
    input  req0, n0, req1, n1,
`ifdef SUM_OVF_EN
    output ovf,
`endif
    output gnt0, gnt1, busy, owner, done0, done1, sum
  );

endinterface

// File: rtl/sum_seq_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] win,
  output logic       last_nxt
);

  logic [1:0] pick;

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    win      = update ? pick : 2'b00;
    last_nxt = last;
    if (win[0]) begin
      last_nxt = 1'b0;
    end else if (win[1]) begin
      last_nxt = 1'b1;
    end
  end

endmodule

// File: rtl/sum_seq_arbiter.sv
// Shared-adder engine computing 1+2+...+N for one of two round-robin requesters, one add per clock.
// Define SUM_OVF_EN to add a sticky carry-out flag (bus.ovf) cleared at each acceptance.
module sum_seq_arbiter
  import sum_seq_pkg::*;
#(
  parameter int WN = DEF_WN,
  parameter int WS = DEF_WS
) (
  input logic              clk,
  input logic              rst_n,
  sum_seq_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic [WN-1:0] nreg_q, nreg_d;
  logic [WN:0]   cnt_q, cnt_d;
  logic [WS-1:0] acc_q, acc_d;
  logic [WS-1:0] sum_q, sum_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          arb_update;
  logic [1:0]    win;
`ifdef SUM_OVF_EN
  logic          ovf_q, ovf_d;
  logic [WS:0]   add_ext;
`endif

  // Arbitration only happens from IDLE; DONE deliberately lets the finished job drain first.
  assign arb_update = (state_q == ST_IDLE) && (bus.req0 || bus.req1);

  rr_arb2 u_arb (
    .req      ({bus.req1, bus.req0}),
    .update   (arb_update),
    .last     (last_q),
    .win      (win),
    .last_nxt (last_d)
  );

  always_comb begin
    state_d = state_q;
    nreg_d  = nreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
`ifdef SUM_OVF_EN
    ovf_d   = ovf_q;
    add_ext = {1'b0, acc_q} + (WS+1)'(cnt_q);
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_update) begin
          owner_d = win[1];
          nreg_d  = win[1] ? bus.n1 : bus.n0;
          acc_d   = '0;
          cnt_d   = (WN+1)'(1);
          gnt0_d  = win[0];
          gnt1_d  = win[1];
          state_d = ST_RUN;
`ifdef SUM_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        // cnt is one bit wider than N so that N at its maximum still terminates.
        if (cnt_q <= {1'b0, nreg_q}) begin
`ifdef SUM_OVF_EN
          acc_d = add_ext[WS-1:0];
          if (add_ext[WS]) begin
            ovf_d = 1'b1;
          end
`else
          acc_d = acc_q + WS'(cnt_q);
`endif
          cnt_d = cnt_q + (WN+1)'(1);
        end else begin
          sum_d   = acc_q;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nreg_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
`ifdef SUM_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      nreg_q  <= nreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef SUM_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;
  assign bus.sum   = sum_q;
`ifdef SUM_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sum_seq_arbiter.sv
// Directed self-checking bench for sum_seq_arbiter: table of single jobs plus hand-written
// sequences for contention, mid-job reset and (with SUM_OVF_EN, WS=6) the overflow flag.
module tb_sum_seq_arbiter;

  localparam int WN = 4;
`ifdef SUM_OVF_EN
  localparam int WS = 6;
`else
  localparam int WS = 7;
`endif

  typedef struct {
    bit sel;
    int n;
    int expSum;
    bit drop;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[8];

  sum_seq_arbiter_if #(.WN(WN), .WS(WS)) bus ();

  sum_seq_arbiter #(.WN(WN), .WS(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r0, input logic [WN-1:0] a0,
                               input bit r1, input logic [WN-1:0] a1);
    bus.req0 = r0;
    bus.n0   = a0;
    bus.req1 = r1;
    bus.n1   = a1;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) checkOutput("idle_wait", 1, 0);
  endtask

  // One job from an idle engine; cycle 1 is the first negedge after the accepting edge.
  task automatic runJob(input bit sel, input int n, input int expSum, input bit drop);
    int gntAt, gntCnt, doneAt, busyCnt, ownerBad, wrongPulse, gotSum;
    int mSum;
`ifdef SUM_OVF_EN
    int gotOvf;
    gotOvf = -1;
`endif
    mSum = expSum % (1 << WS);
    gntAt = -1; gntCnt = 0; doneAt = -1; busyCnt = 0;
    ownerBad = 0; wrongPulse = 0; gotSum = -1;
    waitIdle();
    if (sel) applyStimulus(1'b0, '0, 1'b1, WN'(n));
    else     applyStimulus(1'b1, WN'(n), 1'b0, '0);
    for (int i = 1; i <= 40 && doneAt < 0; i++) begin
      @(negedge clk);
      if ((sel ? bus.gnt1 : bus.gnt0) == 1'b1) begin
        gntCnt++;
        if (gntAt < 0) gntAt = i;
      end
      if ((sel ? bus.gnt0 : bus.gnt1) || (sel ? bus.done0 : bus.done1)) wrongPulse++;
      if (bus.busy) busyCnt++;
      if (bus.owner != sel) ownerBad++;
      if ((sel ? bus.done1 : bus.done0) == 1'b1) begin
        doneAt = i;
        gotSum = int'(bus.sum);
`ifdef SUM_OVF_EN
        gotOvf = int'(bus.ovf);
`endif
      end
      // Operand changes after acceptance must not affect the job in flight.
      if (i == 1) begin
        if (sel) bus.n1 = WN'(~n);
        else     bus.n0 = WN'(~n);
      end
      if (i == 2 && drop) begin
        if (sel) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
      end
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput($sformatf("gnt_cycle n=%0d", n), gntAt, 1);
    checkOutput($sformatf("gnt_count n=%0d", n), gntCnt, 1);
    checkOutput($sformatf("done_cycle n=%0d", n), doneAt, n + 2);
    checkOutput($sformatf("sum n=%0d", n), gotSum, mSum);
    checkOutput($sformatf("owner_bad n=%0d", n), ownerBad, 0);
    checkOutput($sformatf("other_pulse n=%0d", n), wrongPulse, 0);
    checkOutput($sformatf("busy_cycles n=%0d", n), busyCnt, n + 2);
`ifdef SUM_OVF_EN
    checkOutput($sformatf("ovf n=%0d", n), gotOvf, (expSum >= (1 << WS)) ? 1 : 0);
`endif
    @(negedge clk);
    checkOutput($sformatf("idle_after n=%0d", n), int'(bus.busy), 0);
  endtask

  initial begin
    int gseq[4];
    int dseq[4];
    int dsum[4];
    int dAt[4];
    int nG, nD, sawDone;

    checks = 0;
    errors = 0;
    vecs[0] = '{sel: 1'b0, n: 5,  expSum: 15,  drop: 1'b0};
    vecs[1] = '{sel: 1'b1, n: 0,  expSum: 0,   drop: 1'b0};
    vecs[2] = '{sel: 1'b0, n: 15, expSum: 120, drop: 1'b0};
    vecs[3] = '{sel: 1'b0, n: 3,  expSum: 6,   drop: 1'b0};
    vecs[4] = '{sel: 1'b1, n: 7,  expSum: 28,  drop: 1'b1};
    vecs[5] = '{sel: 1'b0, n: 1,  expSum: 1,   drop: 1'b0};
    vecs[6] = '{sel: 1'b1, n: 15, expSum: 120, drop: 1'b0};
    vecs[7] = '{sel: 1'b1, n: 9,  expSum: 45,  drop: 1'b1};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt0", int'(bus.gnt0), 0);
    checkOutput("rst_gnt1", int'(bus.gnt1), 0);
    checkOutput("rst_done0", int'(bus.done0), 0);
    checkOutput("rst_done1", int'(bus.done1), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_owner", int'(bus.owner), 0);
    checkOutput("rst_sum", int'(bus.sum), 0);
`ifdef SUM_OVF_EN
    checkOutput("rst_ovf", int'(bus.ovf), 0);
`endif
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      runJob(vecs[v].sel, vecs[v].n, vecs[v].expSum, vecs[v].drop);
    end

    // Both requesters held from reset: req0 first, then strict alternation.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd4);
    for (int k = 0; k < 4; k++) begin
      gseq[k] = -1; dseq[k] = -1; dsum[k] = -1; dAt[k] = -1;
    end
    nG = 0;
    nD = 0;
    for (int i = 1; i <= 80 && nD < 4; i++) begin
      @(negedge clk);
      if (bus.gnt0 && nG < 4) begin gseq[nG] = 0; nG++; end
      if (bus.gnt1 && nG < 4) begin gseq[nG] = 1; nG++; end
      if ((bus.done0 || bus.done1) && nD < 4) begin
        dseq[nD] = bus.done1 ? 1 : 0;
        dsum[nD] = int'(bus.sum);
        dAt[nD]  = i;
        nD++;
      end
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("both_done_count", nD, 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("both_gnt_order[%0d]", k), gseq[k], k % 2);
      checkOutput($sformatf("both_done_order[%0d]", k), dseq[k], k % 2);
      checkOutput($sformatf("both_sum[%0d]", k), dsum[k], (k % 2 == 1) ? 10 : 6);
    end
    checkOutput("both_done0_cycle", dAt[0], 5);
    checkOutput("both_done1_cycle", dAt[1], 12);

    // Asynchronous reset in the middle of a running n0=9 job.
    waitIdle();
    applyStimulus(1'b1, 4'd9, 1'b0, '0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_busy_before", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_gnt0", int'(bus.gnt0), 0);
    checkOutput("midrst_done0", int'(bus.done0), 0);
    checkOutput("midrst_owner", int'(bus.owner), 0);
    checkOutput("midrst_sum", int'(bus.sum), 0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    sawDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) sawDone = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) sawDone = 1;
    end
    checkOutput("midrst_no_done", sawDone, 0);
    runJob(1'b0, 2, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_seq_arbiter.md
Name: sum_seq_arbiter

Overview:
Multi-cycle sequential sum-of-first-N engine with a single shared adder and two requesters. Round-robin arbitration picks one requester, the block latches that requester's N, and it accumulates 1+2+…+N at one add per clock. The block then returns the result with a per-requester done pulse. It replaces the unrolled combinational loop wherever area matters more than latency.

Parameters:
WN, 4, width of the N operand
WS, 7, width of the sum result (7 holds 120 = sum for N=15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request, level, held until done0
n0  input  WN  requester 0 operand N
req1  input  1  requester 1 request, level, held until done1
n1  input  WN  requester 1 operand N
gnt0  output  1  one-cycle pulse: requester 0 accepted, n0 latched
gnt1  output  1  one-cycle pulse: requester 1 accepted, n1 latched
busy  output  1  high while state != IDLE
owner  output  1  requester currently or last served (0/1)
done0  output  1  one-cycle pulse: sum valid for requester 0
done1  output  1  one-cycle pulse: sum valid for requester 1
sum  output  WS  last completed result; holds until next completion

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, gnt0/gnt1/done0/done1/busy=0, owner=0, sum=0, acc=0, cnt=0, rr pointer favours req0.
- FSM states:
  - IDLE: on an edge with req0|req1, choose the winner, latch n_win into nreg, set acc=0 and cnt=1, pulse gnt_win for the next cycle, set owner, and go to RUN. Otherwise stay in IDLE.
  - RUN: at each edge, if cnt<=nreg then acc<=acc+cnt and cnt<=cnt+1. Otherwise sum<=acc, pulse done_owner for the next cycle, and go to DONE.
  - DONE: go to IDLE unconditionally. No arbitration happens in this cycle.
- Arbitration:
  - Round-robin. If both requests are high, the requester not served last wins.
  - After reset, req0 has priority.
  - A single request always wins.
- Latency: with acceptance at edge k, gnt is high in cycle k+1 and done is high in cycle k+N+2. Throughput is one job per N+3 cycles.
- N=0: the first RUN edge fails cnt<=0, so sum=0 and done arrives 2 cycles after acceptance.
- Counter width:
  - cnt is WN+1 bits so that N=15 terminates (cnt reaches 16, no wrap).
  - acc and sum are WS bits; additions truncate modulo 2^WS.
- Operand sampling: n0/n1 are sampled only at acceptance. Later changes are ignored for the job in flight.
- Request dropped mid-job: the job completes and done still pulses. The requester must ignore the result.
- Request still high after its own done: treated as a new request in IDLE. Round-robin gives the other requester priority if it is also requesting.
- busy is high in RUN and DONE.
- owner is stable from grant through done.
- rst_n asserted mid-RUN: all state and outputs return to reset values immediately. There is no done pulse and the in-flight job is lost.

Optional Feature:
SUM_OVF_EN:
- Defined: adds output ovf (1 bit). ovf clears at acceptance and sets sticky if any addition carries out of WS bits. It is valid with done and held until the next acceptance. Reset value 0.
- Undefined: no ovf port and no carry logic.

Decomposition:
- Shared package sum_seq_pkg:
  - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default widths WN/WS.
- Sub-module rr_arb2: 2-way round-robin arbiter with inputs req[1:0], an update strobe and the last-winner pointer, and a one-hot winner output.
- The FSM and the accumulator datapath stay in the top module.

Test Plan:
1. Reset, then req0=1 with n0=5 → gnt0 in cycle 1 after acceptance; done0 at cycle 7; sum=15; owner=0; gnt1/done1 never set.
2. req1=1 with n1=0 → done1 2 cycles after acceptance; sum=0; busy high for exactly 2 cycles.
3. req0 with n0=15 → done0 at cycle 17; sum=120; FSM returns to IDLE with no hang or wrap.
4. Both requests held, n0=3 and n1=4, from reset:
   - Jobs complete in order req0 then req1, with sum=6 then sum=10.
   - Both still high → next grant goes to req0 and alternates thereafter.
5. rst_n pulsed low mid-RUN of an n0=9 job:
   - All outputs are 0 and state is IDLE immediately.
   - No done0 pulse.
   - After release, a fresh req0 with n0=2 yields sum=3.
6. With SUM_OVF_EN and WS=6, n0=15 → sum=56 (120 mod 64) and ovf=1. The next job with n0=3 → ovf=0.
